// File: rtl/ins_line_fill.sv
// ins_line_fill: memory-side line-fill responder for the instruction fetch path.
// A miss reads the four words of a 16-byte line from a word-wide synchronous
// memory, assembles a 128-bit line and returns it with a one-cycle valid pulse.
// A single-entry last-line buffer answers a repeat request of the same line
// without touching memory. Every output comes straight from a register.
module ins_line_fill #(
  parameter int BUF_EN = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ireq,
  input  logic [31:0]  iaddr,
  input  logic         iflush,
  output logic         omem_en,
  output logic [31:0]  omem_addr,
  input  logic [31:0]  imem_rdata,
  output logic [127:0] oline,
  output logic         ovalid,
  output logic         obusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic [1:0]     k_reg, k_next;
  logic [27:0]    tag_reg, tag_next;
  logic           mem_en_reg, mem_en_next;
  logic [31:0]    mem_addr_reg, mem_addr_next;
  logic [127:0]   line_reg, line_next;
  logic           valid_reg, valid_next;
  logic           busy_reg, busy_next;
  logic           buf_valid_reg, buf_valid_next;
  logic [27:0]    buf_tag_reg, buf_tag_next;

  // Word-slice write control for the line being assembled.
  logic           wr_en;
  logic [1:0]     wr_idx;
  logic [3:0]     slice_we;

  // The offset bits inside the line never affect which line is fetched.
  logic           unused_offset;
  assign unused_offset = ^iaddr[3:0];

  // The returned line register doubles as the buffer data: after a fill it
  // holds exactly the line whose tag the buffer records, and it only changes
  // during the next fill, which ends by rewriting the tag.
  logic           buf_hit;
  assign buf_hit = (BUF_EN != 0) && buf_valid_reg &&
                   (iaddr[31:4] == buf_tag_reg) && !iflush;

  // One write enable per 32-bit slice of the assembled line.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
      localparam logic [1:0] SLICE_IDX = 2'(gi);
      assign slice_we[gi] = wr_en && (wr_idx == SLICE_IDX);
      assign line_next[32*gi +: 32] = slice_we[gi] ? imem_rdata
                                                   : line_reg[32*gi +: 32];
    end
  endgenerate

  // State and output registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      k_reg         <= 2'd0;
      tag_reg       <= 28'd0;
      mem_en_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      line_reg      <= 128'd0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= 28'd0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      tag_reg       <= tag_next;
      mem_en_reg    <= mem_en_next;
      mem_addr_reg  <= mem_addr_next;
      line_reg      <= line_next;
      valid_reg     <= valid_next;
      busy_reg      <= busy_next;
      buf_valid_reg <= buf_valid_next;
      buf_tag_reg   <= buf_tag_next;
    end
  end

  // Next-state and next-output logic for the fill sequencer.
  always_comb begin
    state_next     = state_reg;
    k_next         = k_reg;
    tag_next       = tag_reg;
    mem_en_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    valid_next     = 1'b0;
    busy_next      = busy_reg;
    buf_valid_next = buf_valid_reg && !iflush;
    buf_tag_next   = buf_tag_reg;
    wr_en          = 1'b0;
    wr_idx         = 2'd0;

    case (state_reg)
      IDLE: begin
        if (ireq) begin
          if (buf_hit) begin
            valid_next = 1'b1;
          end else begin
            tag_next      = iaddr[31:4];
            mem_en_next   = 1'b1;
            mem_addr_next = {iaddr[31:4], 4'b0000};
            k_next        = 2'd0;
            busy_next     = 1'b1;
            state_next    = READ;
          end
        end
      end

      READ: begin
        // Data arriving now belongs to the word requested in the previous cycle.
        wr_en  = (k_reg != 2'd0);
        wr_idx = k_reg - 2'd1;
        if (k_reg == 2'd3) begin
          state_next = DRAIN;
        end else begin
          mem_en_next   = 1'b1;
          k_next        = k_reg + 2'd1;
          mem_addr_next = {tag_reg, k_reg + 2'd1, 2'b00};
        end
      end

      DRAIN: begin
        wr_en  = 1'b1;
        wr_idx = 2'd3;
        if ((BUF_EN != 0) && !iflush) begin
          buf_valid_next = 1'b1;
          buf_tag_next   = tag_reg;
        end
        valid_next = 1'b1;
        state_next = RESP;
      end

      RESP: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign omem_en   = mem_en_reg;
  assign omem_addr = mem_addr_reg;
  assign oline     = line_reg;
  assign ovalid    = valid_reg;
  assign obusy     = busy_reg;

endmodule

// File: tb/tb_ins_line_fill.sv
// Directed testbench for ins_line_fill: one buffered instance and one with the
// last-line buffer disabled, each with its own synchronous memory whose word at
// byte address A holds A ^ 32'hA5A5_0000.
module tb_ins_line_fill;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        ireq = 1'b0;
  logic        iflush = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] iaddr = 32'd0;
  logic        ireq1, ireq0;

  assign ireq1 = ireq & ~sel;
  assign ireq0 = ireq & sel;

  logic         en1, valid1, busy1, en0, valid0, busy0;
  logic [31:0]  addr1, addr0;
  logic [31:0]  rd1 = 32'd0;
  logic [31:0]  rd0 = 32'd0;
  logic [127:0] line1, line0;

  ins_line_fill #(.BUF_EN(1)) dut (
    .clk(clk), .rstn(rstn), .ireq(ireq1), .iaddr(iaddr), .iflush(iflush),
    .omem_en(en1), .omem_addr(addr1), .imem_rdata(rd1),
    .oline(line1), .ovalid(valid1), .obusy(busy1)
  );

  ins_line_fill #(.BUF_EN(0)) dut0 (
    .clk(clk), .rstn(rstn), .ireq(ireq0), .iaddr(iaddr), .iflush(iflush),
    .omem_en(en0), .omem_addr(addr0), .imem_rdata(rd0),
    .oline(line0), .ovalid(valid0), .obusy(busy0)
  );

  // Memory models: read data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (en1) rd1 <= addr1 ^ KEY;
    if (en0) rd0 <= addr0 ^ KEY;
  end

  logic         o_en, o_valid, o_busy;
  logic [31:0]  o_addr;
  logic [127:0] o_line;
  assign o_en    = sel ? en0 : en1;
  assign o_valid = sel ? valid0 : valid1;
  assign o_busy  = sel ? busy0 : busy1;
  assign o_addr  = sel ? addr0 : addr1;
  assign o_line  = sel ? line0 : line1;

  int checks = 0;
  int failures = 0;

  // Observations gathered by run_req.
  int           n_rd, n_valid, valid_cyc;
  logic [31:0]  rd_addr [0:7];
  logic         busy_c [0:15];
  logic [127:0] vline;
  logic [163:0] snap;
  logic [127:0] snap2_line;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = a & 32'hFFFF_FFF0;
    return {(b + 32'd12) ^ KEY, (b + 32'd8) ^ KEY, (b + 32'd4) ^ KEY, b ^ KEY};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues one request (pulsed in cycle 0) and records what the selected DUT
  // does over ncyc cycles. Optional: flush pulse, stray request, reset pulse.
  task automatic run_req(input logic [31:0] a, input int ncyc, input int flush_at,
                         input int drop_at, input logic [31:0] drop_a, input int rst_at);
    n_rd = 0; n_valid = 0; valid_cyc = -1; vline = '0;
    snap = '0; snap2_line = '0;
    for (int i = 0; i < 16; i++) busy_c[i] = 1'b0;
    ireq = 1'b1; iaddr = a; iflush = 1'b0; rstn = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      step;
      if (o_en) begin
        if (n_rd < 8) rd_addr[n_rd] = o_addr;
        n_rd++;
      end
      if (o_valid) begin
        n_valid++;
        if (valid_cyc < 0) begin
          valid_cyc = c;
          vline = o_line;
        end
      end
      if (c < 16) busy_c[c] = o_busy;
      if (c == rst_at + 1) snap = {o_en, o_valid, o_busy, 1'b0, o_addr, o_line};
      if (c == rst_at + 2) snap2_line = o_line;
      ireq   = (c == drop_at);
      iaddr  = (c == drop_at) ? drop_a : a;
      iflush = (c == flush_at);
      rstn   = (c != rst_at);
    end
    ireq = 1'b0; iflush = 1'b0; rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; ireq = 1'b0; iflush = 1'b0; sel = 1'b0; iaddr = 32'd0;
    step; step;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if ({en1, valid1, busy1, addr1, line1} !== '0) begin
        failures++;
        $display("FAIL reset_buf cyc%0d: en=%b valid=%b busy=%b addr=%h line=%h, required all 0",
                 i, en1, valid1, busy1, addr1, line1);
      end
      checks++;
      if ({en0, valid0, busy0, addr0, line0} !== '0) begin
        failures++;
        $display("FAIL reset_nobuf cyc%0d: en=%b valid=%b busy=%b addr=%h line=%h, required all 0",
                 i, en0, valid0, busy0, addr0, line0);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_miss;
    run_req(32'h48, 8, -1, -1, 32'd0, -1);
    checks++;
    if (n_rd !== 4) begin failures++; $display("FAIL miss_reads: got %0d, required 4", n_rd); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_addr[k] !== 32'h40 + 32'(4 * k)) begin
        failures++;
        $display("FAIL miss_addr%0d: got %h, required %h", k, rd_addr[k], 32'h40 + 32'(4 * k));
      end
    end
    checks++;
    if (valid_cyc !== 6 || n_valid !== 1) begin
      failures++;
      $display("FAIL miss_valid: cyc=%0d count=%0d, required cyc=6 count=1", valid_cyc, n_valid);
    end
    checks++;
    if (vline !== 128'hA5A5004C_A5A50048_A5A50044_A5A50040) begin
      failures++;
      $display("FAIL miss_line: got %h, required A5A5004CA5A50048A5A50044A5A50040", vline);
    end
    checks++;
    if ({busy_c[1], busy_c[6], busy_c[7]} !== 3'b110) begin
      failures++;
      $display("FAIL miss_busy: T+1,T+6,T+7 = %b%b%b, required 110", busy_c[1], busy_c[6], busy_c[7]);
    end
    $display("test_miss addr=00000048 reads=%0d valid_cyc=%0d", n_rd, valid_cyc);
  endtask

  task automatic test_hit;
    run_req(32'h44, 3, -1, -1, 32'd0, -1);
    checks++;
    if (n_rd !== 0 || valid_cyc !== 1 || n_valid !== 1 || busy_c[1] !== 1'b0) begin
      failures++;
      $display("FAIL hit: reads=%0d valid_cyc=%0d count=%0d busy=%b, required 0/1/1/0",
               n_rd, valid_cyc, n_valid, busy_c[1]);
    end
    checks++;
    if (vline !== line_of(32'h40)) begin
      failures++;
      $display("FAIL hit_line: got %h, required %h", vline, line_of(32'h40));
    end
    $display("test_hit addr=00000044 reads=%0d valid_cyc=%0d", n_rd, valid_cyc);
  endtask

  task automatic test_back_to_back;
    ireq = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      iaddr = 32'h40 + 32'(4 * i);
      step;
      checks++;
      if (valid1 !== 1'b1 || en1 !== 1'b0 || line1 !== line_of(32'h40)) begin
        failures++;
        $display("FAIL b2b_hit%0d: valid=%b en=%b line=%h, required 1/0/%h",
                 i, valid1, en1, line1, line_of(32'h40));
      end
    end
    ireq = 1'b0;
    step;
    checks++;
    if (valid1 !== 1'b0) begin failures++; $display("FAIL b2b_end: valid=%b, required 0", valid1); end
    $display("test_back_to_back three hits");
  endtask

  task automatic test_no_buf;
    sel = 1'b1;
    run_req(32'h48, 8, -1, -1, 32'd0, -1);
    run_req(32'h44, 8, -1, -1, 32'd0, -1);
    checks++;
    if (n_rd !== 4 || valid_cyc !== 6 || rd_addr[0] !== 32'h40) begin
      failures++;
      $display("FAIL nobuf_refill: reads=%0d valid_cyc=%0d addr0=%h, required 4/6/00000040",
               n_rd, valid_cyc, rd_addr[0]);
    end
    checks++;
    if (vline !== line_of(32'h40)) begin
      failures++;
      $display("FAIL nobuf_line: got %h, required %h", vline, line_of(32'h40));
    end
    sel = 1'b0;
    $display("test_no_buf addr=00000044 reads=%0d valid_cyc=%0d", n_rd, valid_cyc);
  endtask

  task automatic test_flush;
    run_req(32'h80, 8, 5, -1, 32'd0, -1);
    checks++;
    if (valid_cyc !== 6 || vline !== line_of(32'h80)) begin
      failures++;
      $display("FAIL flush_fill: valid_cyc=%0d line=%h, required 6/%h", valid_cyc, vline, line_of(32'h80));
    end
    run_req(32'h84, 8, -1, -1, 32'd0, -1);
    checks++;
    if (n_rd !== 4 || rd_addr[0] !== 32'h80 || valid_cyc !== 6) begin
      failures++;
      $display("FAIL flush_miss: reads=%0d addr0=%h valid_cyc=%0d, required 4/00000080/6",
               n_rd, rd_addr[0], valid_cyc);
    end
    $display("test_flush addr=00000084 reads=%0d valid_cyc=%0d", n_rd, valid_cyc);
  endtask

  task automatic test_busy_drop;
    run_req(32'h40, 12, -1, 2, 32'h100, -1);
    checks++;
    if (n_rd !== 4 || rd_addr[0] !== 32'h40 || rd_addr[3] !== 32'h4C) begin
      failures++;
      $display("FAIL drop_reads: reads=%0d addr0=%h addr3=%h, required 4/00000040/0000004c",
               n_rd, rd_addr[0], rd_addr[3]);
    end
    checks++;
    if (n_valid !== 1 || vline !== line_of(32'h40)) begin
      failures++;
      $display("FAIL drop_valid: count=%0d line=%h, required 1/%h", n_valid, vline, line_of(32'h40));
    end
    $display("test_busy_drop addr=00000040 reads=%0d valids=%0d", n_rd, n_valid);
  endtask

  task automatic test_reset_midfill;
    run_req(32'h200, 10, -1, -1, 32'd0, 3);
    checks++;
    if (snap !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: snapshot=%h, required 0", snap);
    end
    checks++;
    if (n_valid !== 0 || snap2_line !== '0) begin
      failures++;
      $display("FAIL midrst_late: valids=%0d line=%h, required 0/0", n_valid, snap2_line);
    end
    run_req(32'h40, 8, -1, -1, 32'd0, -1);
    checks++;
    if (n_rd !== 4 || valid_cyc !== 6 || vline !== line_of(32'h40)) begin
      failures++;
      $display("FAIL midrst_refill: reads=%0d valid_cyc=%0d line=%h, required 4/6/%h",
               n_rd, valid_cyc, vline, line_of(32'h40));
    end
    $display("test_reset_midfill refill reads=%0d valid_cyc=%0d", n_rd, valid_cyc);
  endtask

  initial begin
    test_reset;
    test_miss;
    test_hit;
    test_back_to_back;
    test_no_buf;
    test_flush;
    test_busy_drop;
    test_reset_midfill;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
